keypad_event_scanner: RTL
=========================

KEYPAD_EVENT_SCANNER -- requirements
Module: keypad_event_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12500, clk cycles per scan tick.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, consecutive stable ticks needed to accept a press or a release.
REQ-003 SHALL have port clk, input, 1, system clock (25 MHz).
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port key_row, input, 4, raw keypad row lines, active-high, asynchronous to clk.
REQ-006 SHALL have port key_col, output, 3, one-hot column drive: 001 = col1 (1,4,7,*), 010 = col2 (2,5,8,0), 100 = col3 (3,6,9,#).
REQ-007 SHALL have port key_valid, output, 1, key event pending.
REQ-008 SHALL have port key_code, output, 4, event code: digits 0-9 as value, * = 10, # = 11.
REQ-009 SHALL have port key_ready, input, 1, consumer accepts the event.
REQ-010 SHALL have port key_overrun, output, 1, sticky flag: an event was dropped.

Function
REQ-011 SHALL pass key_row through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-012 SHALL generate a 1-clk scan_tick when the divider reaches CLK_DIV-1, then wrap the divider to 0; all FSM moves occur only on scan_tick.
REQ-013 SHALL implement the FSM states IDLE, SCAN, DEBOUNCE, HELD and RELEASE.
REQ-014 IDLE: key_col=000; on the first tick, go to SCAN with key_col=001.
REQ-015 SCAN: on each tick with row==0000, rotate key_col 001->010->100->001. With a nonzero row, freeze key_col, latch the row pattern, set cnt=1, go to DEBOUNCE.
REQ-016 DEBOUNCE: on each tick, if row equals the latched pattern, increment cnt; if cnt reaches DEBOUNCE_TICKS, go to HELD.
REQ-017 DEBOUNCE: if row==0000, go to SCAN and rotate key_col.
REQ-018 DEBOUNCE: if row differs from the latched pattern and is nonzero, re-latch the pattern and set cnt=1.
REQ-019 A latched pattern that is not one-hot (more than one row bit set) SHALL never qualify; on the qualifying tick the FSM goes to RELEASE and no event is issued.
REQ-020 On entry to HELD, SHALL issue exactly one event with key_code decoded from (key_col, row).
REQ-021 HELD: stay while row!=0000; on the first tick with row==0000, set cnt=1 and go to RELEASE.
REQ-022 RELEASE: any nonzero row sets cnt=0; cnt reaching DEBOUNCE_TICKS consecutive zero-row ticks goes to SCAN with key_col unchanged.
REQ-023 Event handshake: key_valid and key_code assert on the clk after the qualifying tick.
REQ-024 key_valid and key_code SHALL hold stable until a clk edge with key_valid&key_ready, then key_valid clears on that edge.
REQ-025 If a new event arises while key_valid=1 and key_ready=0, SHALL drop the new event, keep the old code, and set key_overrun=1 until reset.
REQ-026 If a new event arises on the same clk as an acceptance, SHALL load the new event; it is not an overrun.
REQ-027 Latency from a clean, stable press to key_valid SHALL be at most (3+DEBOUNCE_TICKS) ticks plus 3 clk.

Reset
REQ-028 rst SHALL immediately set the FSM to IDLE, key_col=000, key_valid=0, key_code=0, key_overrun=0, divider=0, cnt=0 and synchronizer=0.
REQ-029 rst asserted mid-press or while an event is pending SHALL discard everything; after release of rst, a key still held is re-debounced and reported once.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the column one-hot constants, and the key codes KEY_STAR=10 and KEY_HASH=11.
REQ-031 The divider SHALL be a sub-module scan_tick_gen (parameter CLK_DIV; outputs tick).
REQ-032 The remaining logic (synchronizer, FSM, decode and handshake) SHALL reside in keypad_event_scanner.

Verification (CLK_DIV=4, DEBOUNCE_TICKS=3)
REQ-033 After reset, with no key pressed: key_col cycles 001,010,100,001 every 4 clk, and key_valid stays 0 for 200 clk.
REQ-034 Hold key_row=0010 while key_col=010, with key_ready=1: exactly one pulse of key_valid with key_code=5; holding the key for 100 clk more gives no further event.
REQ-035 Toggle key_row 0001/0000 every tick for 10 ticks on col3, then hold it stable: no event during the bounce; afterwards exactly one event with key_code=3.
REQ-036 With key_ready=0, press and release * (col1, row 1000), then # (col3, row 1000): key_valid=1 with key_code=10, then key_overrun=1 with key_code still 10; raising key_ready clears key_valid.
REQ-037 Press key_row=0110 on col2: no event; after release, pressing 8 (row 0100) yields key_code=8.
REQ-038 Assert rst while key_valid=1 and 7 is held: all outputs are 0 during rst; after rst, key_code=7 is reported once.

Source files
------------

// File: rtl/keypad_event_scanner_pkg.sv
// Shared types and constants for the 3x4 keypad scanner: FSM states, column
// drive patterns, special key codes and small decode helpers.
package keypad_event_scanner_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SCAN     = 3'd1,
      ST_DEBOUNCE = 3'd2,
      ST_HELD     = 3'd3,
      ST_RELEASE  = 3'd4
   } state_t;

   localparam logic [2:0] COL_NONE = 3'b000;
   localparam logic [2:0] COL1     = 3'b001;
   localparam logic [2:0] COL2     = 3'b010;
   localparam logic [2:0] COL3     = 3'b100;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   function automatic logic [2:0] col_rotate(input logic [2:0] col);
      case (col)
         COL1:    return COL2;
         COL2:    return COL3;
         default: return COL1;
      endcase
   endfunction

   function automatic logic row_one_hot(input logic [3:0] row);
      return (row != 4'b0000) && ((row & (row - 4'd1)) == 4'b0000);
   endfunction

   // Row bit 0 is the top row (1,2,3); row bit 3 is the bottom row (*,0,#).
   function automatic logic [3:0] key_decode(input logic [2:0] col, input logic [3:0] row);
      logic [3:0] c;
      logic [3:0] code;
      c = col[2] ? 4'd2 : (col[1] ? 4'd1 : 4'd0);
      case (row)
         4'b0001: code = 4'd1 + c;
         4'b0010: code = 4'd4 + c;
         4'b0100: code = 4'd7 + c;
         default: begin
            case (c)
               4'd0:    code = KEY_STAR;
               4'd1:    code = 4'd0;
               default: code = KEY_HASH;
            endcase
         end
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_event_scanner_scan_tick_gen.sv
// Free-running clock divider: one-cycle tick every CLK_DIV clocks, no backpressure.
// Tick is high while the count sits at CLK_DIV-1; the count then wraps to 0.
module scan_tick_gen #(
   parameter int CLK_DIV = 12500
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] div_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else if (div_q == LAST) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + W'(1);
      end
   end

   assign tick = (div_q == LAST);

endmodule

// File: rtl/keypad_event_scanner.sv
// Scans a 3x4 keypad, debounces press/release and emits one key event per press.
// Event appears one clk after the qualifying tick; held until key_ready, extra events dropped (overrun).
module keypad_event_scanner
   import keypad_event_scanner_pkg::*;
#(
   parameter int CLK_DIV        = 12500,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_row,
   output logic [2:0] key_col,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ready,
   output logic       key_overrun
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic          scan_tick;

   state_t        state_q, state_d;
   logic [2:0]    col_q, col_d;
   logic [3:0]    pat_q, pat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          new_event;
   logic [3:0]    event_code;

   scan_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (scan_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta <= 4'b0000;
         row_sync <= 4'b0000;
      end else begin
         row_meta <= key_row;
         row_sync <= row_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         col_q   <= COL_NONE;
         pat_q   <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      pat_d     = pat_q;
      cnt_d     = cnt_q;
      new_event = 1'b0;
      if (scan_tick) begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SCAN;
               col_d   = COL1;
            end
            ST_SCAN: begin
               if (row_sync == 4'b0000) begin
                  col_d = col_rotate(col_q);
               end else begin
                  pat_d   = row_sync;
                  cnt_d   = CNT_ONE;
                  state_d = ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (row_sync == 4'b0000) begin
                  state_d = ST_SCAN;
                  col_d   = col_rotate(col_q);
                  cnt_d   = '0;
               end else if (row_sync != pat_q) begin
                  pat_d = row_sync;
                  cnt_d = CNT_ONE;
               end else if (cnt_q >= CNT_LAST) begin
                  // Ghosted/multi-key patterns are waited out in RELEASE silently.
                  cnt_d = '0;
                  if (row_one_hot(pat_q)) begin
                     state_d   = ST_HELD;
                     new_event = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (row_sync == 4'b0000) begin
                  cnt_d   = CNT_ONE;
                  state_d = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (row_sync != 4'b0000) begin
                  cnt_d = '0;
               end else if (cnt_q >= CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_SCAN;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               col_d   = COL_NONE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign event_code = key_decode(col_q, pat_q);
   assign key_col    = col_q;

   // A slot freed by acceptance on this edge can take the new event at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_valid   <= 1'b0;
         key_code    <= 4'd0;
         key_overrun <= 1'b0;
      end else begin
         if (new_event && (!key_valid || key_ready)) begin
            key_valid <= 1'b1;
            key_code  <= event_code;
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
         if (new_event && key_valid && !key_ready) begin
            key_overrun <= 1'b1;
         end
      end
   end

endmodule
